bullet_ctrl: RTL and testbench

//  Single-bullet engine for one tank: spawns a bullet on fire, advances it once per frame, detects

---
 rtl/bullet_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_bullet_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_ctrl.sv
// Single-bullet engine for one tank: spawn on fire, advance once per frame,
// latch hard-block impacts seen by the raster, and drive the map's collide
// input over the bullet box for one frame after an impact.
module bullet_ctrl #(
    parameter int unsigned           COLOR_BITS   = 24,
    parameter int unsigned           BULLET_SIZE  = 4,
    parameter int unsigned           SPEED        = 4,
    parameter int unsigned           H_MAX        = 640,
    parameter int unsigned           V_MAX        = 480,
    parameter logic [COLOR_BITS-1:0] BULLET_COLOR = 24'hFFFFFF
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    frame_tick_i,
    input  logic                    fire_i,
    input  logic [9:0]              tank_x_i,
    input  logic [9:0]              tank_y_i,
    input  logic [1:0]              tank_dir_i,
    input  logic                    display_enable_i,
    input  logic [9:0]              hpos_i,
    input  logic [9:0]              vpos_i,
    input  logic                    all_hard_block_i,
    output logic                    bullet_collide_o,
    output logic                    bullet_enable_o,
    output logic [COLOR_BITS/3-1:0] bullet_blue_o,
    output logic [COLOR_BITS/3-1:0] bullet_green_o,
    output logic [COLOR_BITS/3-1:0] bullet_red_o,
    output logic                    bullet_active_o,
    output logic                    hit_o
);

    localparam int unsigned CW = COLOR_BITS / 3;

    // 12-bit working width leaves headroom for tank + 32 + size without wrap.
    localparam logic [11:0] SZ   = 12'(BULLET_SIZE);
    localparam logic [11:0] HALF = 12'(BULLET_SIZE / 2);
    localparam logic [11:0] SP   = 12'(SPEED);
    localparam logic [11:0] HM   = 12'(H_MAX);
    localparam logic [11:0] VM   = 12'(V_MAX);

    typedef enum logic [1:0] {StIdle, StFly, StHit} state_e;

    state_e     state_q, state_d;
    logic [9:0] bx_q, bx_d;
    logic [9:0] by_q, by_d;
    logic [1:0] dir_q, dir_d;
    logic       hit_flag_q, hit_flag_d;

    logic [11:0] bx12, by12, hp12, vp12, tx12, ty12;
    logic [11:0] spawn_x, spawn_y, move_x, move_y;
    logic        spawn_under, spawn_ok, move_out;
    logic        in_box, hit_px;

    assign bx12 = {2'b00, bx_q};
    assign by12 = {2'b00, by_q};
    assign hp12 = {2'b00, hpos_i};
    assign vp12 = {2'b00, vpos_i};
    assign tx12 = {2'b00, tank_x_i};
    assign ty12 = {2'b00, tank_y_i};

    // Raster currently inside the bullet square.
    always_comb begin
        in_box = display_enable_i
              && (hp12 >= bx12) && (hp12 < bx12 + SZ)
              && (vp12 >= by12) && (vp12 < by12 + SZ);
        hit_px = in_box && all_hard_block_i;
    end

    // Spawn position at the muzzle for the tank's current heading, plus legality.
    always_comb begin
        spawn_x     = tx12 + 12'd16 - HALF;
        spawn_y     = ty12 + 12'd16 - HALF;
        spawn_under = 1'b0;
        case (tank_dir_i)
            2'd0: begin
                spawn_y     = ty12 - SZ;
                spawn_under = ty12 < SZ;
            end
            2'd1: spawn_x = tx12 + 12'd32;
            2'd2: spawn_y = ty12 + 12'd32;
            default: begin
                spawn_x     = tx12 - SZ;
                spawn_under = tx12 < SZ;
            end
        endcase
        spawn_ok = !spawn_under && (spawn_x + SZ <= HM) && (spawn_y + SZ <= VM);
    end

    // One-frame step in the latched direction; move_out means the bullet leaves the screen.
    always_comb begin
        move_x   = bx12;
        move_y   = by12;
        move_out = 1'b0;
        case (dir_q)
            2'd0: begin
                move_y   = by12 - SP;
                move_out = by12 < SP;
            end
            2'd1: begin
                move_x   = bx12 + SP;
                move_out = bx12 + SZ + SP > HM;
            end
            2'd2: begin
                move_y   = by12 + SP;
                move_out = by12 + SZ + SP > VM;
            end
            default: begin
                move_x   = bx12 - SP;
                move_out = bx12 < SP;
            end
        endcase
    end

    // Next-state: spawn, per-frame advance/impact, one collide frame after a hit.
    always_comb begin
        state_d    = state_q;
        bx_d       = bx_q;
        by_d       = by_q;
        dir_d      = dir_q;
        hit_flag_d = hit_flag_q;
        hit_o      = 1'b0;
        case (state_q)
            StIdle: begin
                if (fire_i && spawn_ok) begin
                    state_d    = StFly;
                    bx_d       = spawn_x[9:0];
                    by_d       = spawn_y[9:0];
                    dir_d      = tank_dir_i;
                    hit_flag_d = 1'b0;
                end
            end
            StFly: begin
                if (frame_tick_i) begin
                    if (hit_flag_q || hit_px) begin
                        state_d    = StHit;
                        hit_flag_d = 1'b0;
                        hit_o      = 1'b1;
                    end else if (move_out) begin
                        state_d = StIdle;
                    end else begin
                        bx_d = move_x[9:0];
                        by_d = move_y[9:0];
                    end
                end else if (hit_px) begin
                    hit_flag_d = 1'b1;
                end
            end
            StHit: begin
                if (frame_tick_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            bx_q       <= '0;
            by_q       <= '0;
            dir_q      <= '0;
            hit_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            dir_q      <= dir_d;
            hit_flag_q <= hit_flag_d;
        end
    end

    // Pixel outputs are combinational so map_rgb sees collide on the scanned pixel itself.
    always_comb begin
        bullet_enable_o  = in_box && (state_q == StFly);
        bullet_collide_o = in_box && (state_q == StHit);
        bullet_active_o  = state_q != StIdle;
        bullet_red_o     = bullet_enable_o ? BULLET_COLOR[CW-1:0]      : '0;
        bullet_green_o   = bullet_enable_o ? BULLET_COLOR[2*CW-1:CW]   : '0;
        bullet_blue_o    = bullet_enable_o ? BULLET_COLOR[3*CW-1:2*CW] : '0;
    end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Bench for bullet_ctrl: directed scenarios plus a randomized run against a
// pixel-geometry model of the bullet (integer positions, screen-bounds rules).
module tb_bullet_ctrl;

    localparam int S  = 4;
    localparam int SP = 4;
    localparam int HM = 640;
    localparam int VM = 480;

    logic       clk_i = 1'b0;
    logic       reset_i, frame_tick_i, fire_i;
    logic [9:0] tank_x_i, tank_y_i;
    logic [1:0] tank_dir_i;
    logic       display_enable_i;
    logic [9:0] hpos_i, vpos_i;
    logic       all_hard_block_i;
    logic       bullet_collide_o, bullet_enable_o, bullet_active_o, hit_o;
    logic [7:0] bullet_blue_o, bullet_green_o, bullet_red_o;

    int checks   = 0;
    int failures = 0;

    // Model state: 0 idle, 1 flying, 2 hit frame.
    int m_st, m_x, m_y, m_dir;
    bit m_flag;

    bullet_ctrl dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .frame_tick_i     (frame_tick_i),
        .fire_i           (fire_i),
        .tank_x_i         (tank_x_i),
        .tank_y_i         (tank_y_i),
        .tank_dir_i       (tank_dir_i),
        .display_enable_i (display_enable_i),
        .hpos_i           (hpos_i),
        .vpos_i           (vpos_i),
        .all_hard_block_i (all_hard_block_i),
        .bullet_collide_o (bullet_collide_o),
        .bullet_enable_o  (bullet_enable_o),
        .bullet_blue_o    (bullet_blue_o),
        .bullet_green_o   (bullet_green_o),
        .bullet_red_o     (bullet_red_o),
        .bullet_active_o  (bullet_active_o),
        .hit_o            (hit_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic cyc;
        @(posedge clk_i);
        #1;
    endtask

    task automatic probe(input int h, input int v);
        hpos_i = 10'(h);
        vpos_i = 10'(v);
        #1;
    endtask

    task automatic fire_tank(input int x, input int y, input int d);
        tank_x_i   = 10'(x);
        tank_y_i   = 10'(y);
        tank_dir_i = 2'(d);
        fire_i     = 1'b1;
        cyc();
        fire_i     = 1'b0;
    endtask

    task automatic do_reset;
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0;
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        tank_x_i = 10'd100; tank_y_i = 10'd200; tank_dir_i = 2'd1; fire_i = 1'b1;
        cyc(); cyc();
        reset_i = 1'b0;
        fire_i  = 1'b0;
        probe(0, 0);
        checks++; if (bullet_active_o !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", bullet_active_o); end
        checks++; if (bullet_enable_o !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", bullet_enable_o); end
        checks++; if (bullet_collide_o !== 1'b0) begin failures++; $display("FAIL reset_collide got=%b exp=0", bullet_collide_o); end
        checks++; if (hit_o !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hit_o); end
        checks++; if ({bullet_blue_o, bullet_green_o, bullet_red_o} !== 24'h0) begin
            failures++; $display("FAIL reset_colour got=%h exp=0", {bullet_blue_o, bullet_green_o, bullet_red_o}); end
    endtask

    task automatic test_spawn_move;
        fire_tank(100, 200, 1);
        probe(132, 214);
        checks++; if (bullet_enable_o !== 1'b1) begin failures++; $display("FAIL spawn_tl got=%b exp=1", bullet_enable_o); end
        checks++; if (bullet_red_o !== 8'hFF) begin failures++; $display("FAIL spawn_red got=%h exp=ff", bullet_red_o); end
        probe(131, 214);
        checks++; if (bullet_enable_o !== 1'b0) begin failures++; $display("FAIL spawn_left got=%b exp=0", bullet_enable_o); end
        probe(135, 217);
        checks++; if (bullet_enable_o !== 1'b1) begin failures++; $display("FAIL spawn_br got=%b exp=1", bullet_enable_o); end
        probe(136, 217);
        checks++; if (bullet_enable_o !== 1'b0) begin failures++; $display("FAIL spawn_right got=%b exp=0", bullet_enable_o); end
        repeat (3) begin
            frame_tick_i = 1'b1; cyc(); frame_tick_i = 1'b0; cyc();
        end
        probe(144, 214);
        checks++; if (bullet_enable_o !== 1'b1) begin failures++; $display("FAIL move_tl got=%b exp=1", bullet_enable_o); end
        probe(143, 214);
        checks++; if (bullet_enable_o !== 1'b0) begin failures++; $display("FAIL move_left got=%b exp=0", bullet_enable_o); end
        probe(147, 217);
        checks++; if (bullet_enable_o !== 1'b1) begin failures++; $display("FAIL move_br got=%b exp=1", bullet_enable_o); end
        probe(148, 217);
        checks++; if (bullet_enable_o !== 1'b0) begin failures++; $display("FAIL move_right got=%b exp=0", bullet_enable_o); end
    endtask

    // Continues the flight from test_spawn_move (bx=144) to bx=200, then resets.
    task automatic test_reset_mid_flight;
        repeat (14) begin
            frame_tick_i = 1'b1; cyc(); frame_tick_i = 1'b0; cyc();
        end
        probe(200, 214);
        checks++; if (bullet_enable_o !== 1'b1) begin failures++; $display("FAIL fly_200 got=%b exp=1", bullet_enable_o); end
        do_reset();
        probe(200, 214);
        checks++; if (bullet_active_o !== 1'b0) begin failures++; $display("FAIL midrst_active got=%b exp=0", bullet_active_o); end
        checks++; if (bullet_enable_o !== 1'b0) begin failures++; $display("FAIL midrst_enable got=%b exp=0", bullet_enable_o); end
        fire_tank(100, 200, 1);
        probe(132, 214);
        checks++; if (bullet_active_o !== 1'b1) begin failures++; $display("FAIL refire_active got=%b exp=1", bullet_active_o); end
        checks++; if (bullet_enable_o !== 1'b1) begin failures++; $display("FAIL refire_pos got=%b exp=1", bullet_enable_o); end
        do_reset();
    endtask

    task automatic test_hit_collide;
        int ones;
        bit exp;
        fire_tank(64, 300, 0);
        probe(78, 296);
        checks++; if (bullet_enable_o !== 1'b1) begin failures++; $display("FAIL up_spawn got=%b exp=1", bullet_enable_o); end
        all_hard_block_i = 1'b1;
        cyc();
        all_hard_block_i = 1'b0;
        #1;
        checks++; if (hit_o !== 1'b0) begin failures++; $display("FAIL hit_early got=%b exp=0", hit_o); end
        frame_tick_i = 1'b1;
        #1;
        checks++; if (hit_o !== 1'b1) begin failures++; $display("FAIL hit_pulse got=%b exp=1", hit_o); end
        cyc();
        frame_tick_i = 1'b0;
        #1;
        checks++; if (hit_o !== 1'b0) begin failures++; $display("FAIL hit_after got=%b exp=0", hit_o); end
        checks++; if (bullet_active_o !== 1'b1) begin failures++; $display("FAIL hit_active got=%b exp=1", bullet_active_o); end
        ones = 0;
        for (int v = 292; v < 304; v++) begin
            for (int h = 74; h < 86; h++) begin
                probe(h, v);
                exp = (h >= 78 && h <= 81 && v >= 296 && v <= 299);
                checks++; if (bullet_collide_o !== exp) begin
                    failures++; $display("FAIL collide_px(%0d,%0d) got=%b exp=%b", h, v, bullet_collide_o, exp); end
                checks++; if (bullet_enable_o !== 1'b0) begin
                    failures++; $display("FAIL hit_enable(%0d,%0d) got=%b exp=0", h, v, bullet_enable_o); end
                if (bullet_collide_o === 1'b1) ones++;
                cyc();
            end
        end
        checks++; if (ones != 16) begin failures++; $display("FAIL collide_count got=%0d exp=16", ones); end
        frame_tick_i = 1'b1; cyc(); frame_tick_i = 1'b0;
        #1;
        checks++; if (bullet_active_o !== 1'b0) begin failures++; $display("FAIL hit_to_idle got=%b exp=0", bullet_active_o); end
    endtask

    task automatic test_retire_top;
        fire_tank(200, 3, 0);
        #1;
        checks++; if (bullet_active_o !== 1'b0) begin failures++; $display("FAIL spawn_under got=%b exp=0", bullet_active_o); end
        fire_tank(200, 10, 0);
        probe(214, 6);
        checks++; if (bullet_enable_o !== 1'b1) begin failures++; $display("FAIL top_spawn got=%b exp=1", bullet_enable_o); end
        frame_tick_i = 1'b1; #1;
        checks++; if (hit_o !== 1'b0) begin failures++; $display("FAIL top_hit1 got=%b exp=0", hit_o); end
        cyc(); frame_tick_i = 1'b0;
        probe(214, 2);
        checks++; if (bullet_enable_o !== 1'b1) begin failures++; $display("FAIL top_by2 got=%b exp=1", bullet_enable_o); end
        probe(214, 6);
        checks++; if (bullet_enable_o !== 1'b0) begin failures++; $display("FAIL top_by6_gone got=%b exp=0", bullet_enable_o); end
        frame_tick_i = 1'b1; #1;
        checks++; if (hit_o !== 1'b0) begin failures++; $display("FAIL top_hit2 got=%b exp=0", hit_o); end
        cyc(); frame_tick_i = 1'b0; #1;
        checks++; if (bullet_active_o !== 1'b0) begin failures++; $display("FAIL top_retire got=%b exp=0", bullet_active_o); end
    endtask

    task automatic test_fire_held;
        tank_x_i = 10'd300; tank_y_i = 10'd200; tank_dir_i = 2'd2; fire_i = 1'b1;
        cyc();
        probe(314, 232);
        checks++; if (bullet_enable_o !== 1'b1) begin failures++; $display("FAIL held_spawn got=%b exp=1", bullet_enable_o); end
        frame_tick_i = 1'b1; cyc(); frame_tick_i = 1'b0; cyc();
        probe(314, 236);
        checks++; if (bullet_enable_o !== 1'b1) begin failures++; $display("FAIL held_moved got=%b exp=1", bullet_enable_o); end
        probe(314, 232);
        checks++; if (bullet_enable_o !== 1'b0) begin failures++; $display("FAIL held_respawn got=%b exp=0", bullet_enable_o); end
        probe(315, 237);
        all_hard_block_i = 1'b1; cyc(); all_hard_block_i = 1'b0;
        frame_tick_i = 1'b1; #1;
        checks++; if (hit_o !== 1'b1) begin failures++; $display("FAIL held_hit got=%b exp=1", hit_o); end
        cyc(); frame_tick_i = 1'b0;
        repeat (3) cyc();
        probe(314, 236);
        checks++; if (bullet_collide_o !== 1'b1) begin failures++; $display("FAIL held_collide got=%b exp=1", bullet_collide_o); end
        checks++; if (bullet_active_o !== 1'b1) begin failures++; $display("FAIL held_hit_active got=%b exp=1", bullet_active_o); end
        frame_tick_i = 1'b1; cyc(); frame_tick_i = 1'b0;
        probe(314, 232);
        checks++; if (bullet_active_o !== 1'b0) begin failures++; $display("FAIL held_idle got=%b exp=0", bullet_active_o); end
        checks++; if (bullet_enable_o !== 1'b0) begin failures++; $display("FAIL held_idle_en got=%b exp=0", bullet_enable_o); end
        cyc();
        probe(314, 232);
        checks++; if (bullet_enable_o !== 1'b1) begin failures++; $display("FAIL held_refire got=%b exp=1", bullet_enable_o); end
        fire_i = 1'b0;
        do_reset();
    endtask

    task automatic test_hit_on_tick;
        fire_tank(300, 200, 1);
        probe(333, 215);
        all_hard_block_i = 1'b1;
        frame_tick_i     = 1'b1;
        #1;
        checks++; if (hit_o !== 1'b1) begin failures++; $display("FAIL tick_hit got=%b exp=1", hit_o); end
        cyc();
        all_hard_block_i = 1'b0;
        frame_tick_i     = 1'b0;
        probe(332, 214);
        checks++; if (bullet_collide_o !== 1'b1) begin failures++; $display("FAIL tick_frozen got=%b exp=1", bullet_collide_o); end
        probe(336, 214);
        checks++; if (bullet_collide_o !== 1'b0) begin failures++; $display("FAIL tick_nomove got=%b exp=0", bullet_collide_o); end
        frame_tick_i = 1'b1; cyc(); frame_tick_i = 1'b0; #1;
        checks++; if (bullet_active_o !== 1'b0) begin failures++; $display("FAIL tick_idle got=%b exp=0", bullet_active_o); end
    endtask

    task automatic test_random;
        int tx, ty, td, h, v, nx, ny;
        bit rst, fire, tick, de, hard, inb, e_en, e_col, e_act, e_hit;
        do_reset();
        m_st = 0; m_x = 0; m_y = 0; m_dir = 0; m_flag = 0;
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(499) == 0);
            fire = ($urandom_range(7) == 0);
            tick = ($urandom_range(29) == 0);
            de   = ($urandom_range(7) != 0);
            hard = ($urandom_range(5) == 0);
            td   = int'($urandom_range(3));
            case ($urandom_range(3))
                0:       begin tx = int'($urandom_range(15));      ty = int'($urandom_range(15)); end
                1:       begin tx = 590 + int'($urandom_range(33)); ty = 430 + int'($urandom_range(40)); end
                default: begin tx = int'($urandom_range(623));     ty = int'($urandom_range(470)); end
            endcase
            if ($urandom_range(1) == 1) begin
                h = m_x + int'($urandom_range(S + 3)) - 2;
                v = m_y + int'($urandom_range(S + 3)) - 2;
            end else begin
                h = int'($urandom_range(1023));
                v = int'($urandom_range(1023));
            end
            h = h & 1023;
            v = v & 1023;
            reset_i = rst; fire_i = fire; frame_tick_i = tick; display_enable_i = de;
            all_hard_block_i = hard;
            tank_x_i = 10'(tx); tank_y_i = 10'(ty); tank_dir_i = 2'(td);
            hpos_i = 10'(h); vpos_i = 10'(v);
            #1;
            inb   = de && h >= m_x && h < m_x + S && v >= m_y && v < m_y + S;
            e_en  = inb && m_st == 1;
            e_col = inb && m_st == 2;
            e_act = m_st != 0;
            e_hit = m_st == 1 && tick && (m_flag || (inb && hard));
            checks++; if (bullet_enable_o !== e_en) begin
                failures++; $display("FAIL rnd_enable n=%0d got=%b exp=%b", n, bullet_enable_o, e_en); end
            checks++; if (bullet_collide_o !== e_col) begin
                failures++; $display("FAIL rnd_collide n=%0d got=%b exp=%b", n, bullet_collide_o, e_col); end
            checks++; if (bullet_active_o !== e_act) begin
                failures++; $display("FAIL rnd_active n=%0d got=%b exp=%b", n, bullet_active_o, e_act); end
            checks++; if (hit_o !== e_hit) begin
                failures++; $display("FAIL rnd_hit n=%0d got=%b exp=%b", n, hit_o, e_hit); end
            checks++; if ({bullet_blue_o, bullet_green_o, bullet_red_o} !== (e_en ? 24'hFFFFFF : 24'h0)) begin
                failures++; $display("FAIL rnd_colour n=%0d got=%h exp_en=%b", n,
                                     {bullet_blue_o, bullet_green_o, bullet_red_o}, e_en); end
            cyc();
            // Model update for the edge just taken.
            if (rst) begin
                m_st = 0; m_x = 0; m_y = 0; m_dir = 0; m_flag = 0;
            end else if (m_st == 0) begin
                if (fire) begin
                    case (td)
                        0:       begin nx = tx + 16 - S / 2; ny = ty - S;          end
                        1:       begin nx = tx + 32;         ny = ty + 16 - S / 2; end
                        2:       begin nx = tx + 16 - S / 2; ny = ty + 32;         end
                        default: begin nx = tx - S;          ny = ty + 16 - S / 2; end
                    endcase
                    if (nx >= 0 && ny >= 0 && nx + S <= HM && ny + S <= VM) begin
                        m_st = 1; m_x = nx; m_y = ny; m_dir = td; m_flag = 0;
                    end
                end
            end else if (m_st == 1) begin
                if (tick) begin
                    if (m_flag || (inb && hard)) begin
                        m_st = 2; m_flag = 0;
                    end else begin
                        nx = m_x + ((m_dir == 1) ? SP : (m_dir == 3) ? -SP : 0);
                        ny = m_y + ((m_dir == 2) ? SP : (m_dir == 0) ? -SP : 0);
                        if (nx >= 0 && ny >= 0 && nx + S <= HM && ny + S <= VM) begin
                            m_x = nx; m_y = ny;
                        end else begin
                            m_st = 0;
                        end
                    end
                end else if (inb && hard) begin
                    m_flag = 1;
                end
            end else if (tick) begin
                m_st = 0;
            end
        end
        reset_i = 1'b0; fire_i = 1'b0; frame_tick_i = 1'b0; all_hard_block_i = 1'b0;
        display_enable_i = 1'b1;
    endtask

    initial begin
        reset_i = 1'b1; frame_tick_i = 1'b0; fire_i = 1'b0;
        tank_x_i = '0; tank_y_i = '0; tank_dir_i = '0;
        display_enable_i = 1'b1; hpos_i = '0; vpos_i = '0; all_hard_block_i = 1'b0;
        test_reset();
        test_spawn_move();
        test_reset_mid_flight();
        test_hit_collide();
        test_retire_top();
        test_fire_held();
        test_hit_on_tick();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
